// File: rtl/btn_pkg.sv
// btn_pkg: shared channel state encoding, edge-mode constants and counter sizing.
package btn_pkg;
  typedef enum logic [2:0] {
    ST_RESET,
    ST_NOT_PUSHED,
    ST_DEB_PRESS,
    ST_PUSHED,
    ST_DEB_RELEASE
  } btn_state_t;
  localparam int EDGE_RELEASE = 0;
  localparam int EDGE_PRESS   = 1;
  function automatic int cnt_width(input int d, input int a, input int b);
    int m;
    m = d;
    if (a > m) m = a;
    if (b > m) m = b;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: synchronizer, debounce FSM and auto-repeat for one button.
module button_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = EDGE_RELEASE,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic held
);
  localparam int W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [W-1:0] DEB_MAX   = W'(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] DELAY_LIM = W'(REPEAT_DELAY - 1);
  localparam logic [W-1:0] RATE_LIM  = W'(REPEAT_RATE - 1);
  localparam logic [W-1:0] CNT_MAX   = {W{1'b1}};
  localparam bit RPT = (REPEAT_EN != 0) && (EDGE_MODE == EDGE_PRESS);
  localparam bit PRESS_PULSE = (EDGE_MODE == EDGE_PRESS);
  btn_state_t state_q;
  logic sync1_q, s_q, v1_q, v2_q;
  logic [W-1:0] deb_q, rpt_q;
  logic rep_phase_q, dout_q, held_q;
  logic rpt_hit_d;
  assign dout = dout_q;
  assign held = held_q;
  always_comb rpt_hit_d = rpt_q == (rep_phase_q ? RATE_LIM : DELAY_LIM);
  // v2_q marks s_q as a real post-reset sample, so a button held through reset stays in RESET
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      sync1_q     <= 1'b0;
      s_q         <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      deb_q       <= '0;
      rpt_q       <= '0;
      rep_phase_q <= 1'b0;
      dout_q      <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      sync1_q <= din;
      s_q     <= sync1_q;
      v1_q    <= 1'b1;
      v2_q    <= v1_q;
      dout_q  <= 1'b0;
      if (state_q != ST_PUSHED && state_q != ST_DEB_RELEASE) begin
        rpt_q       <= '0;
        rep_phase_q <= 1'b0;
      end
      case (state_q)
        ST_RESET: if (v2_q && !s_q) state_q <= ST_NOT_PUSHED;
        ST_NOT_PUSHED: if (s_q) begin
          state_q <= ST_DEB_PRESS;
          deb_q   <= W'(1);
        end
        ST_DEB_PRESS: begin
          if (!s_q) state_q <= ST_NOT_PUSHED;
          else if (deb_q == DEB_MAX) begin
            state_q <= ST_PUSHED;
            dout_q  <= PRESS_PULSE;
            held_q  <= 1'b1;
          end else deb_q <= deb_q + W'(deb_q != CNT_MAX);
        end
        ST_PUSHED: begin
          if (!s_q) begin
            state_q <= ST_DEB_RELEASE;
            deb_q   <= W'(1);
          end
          if (RPT) begin
            if (rpt_hit_d) begin
              dout_q      <= 1'b1;
              rpt_q       <= '0;
              rep_phase_q <= 1'b1;
            end else rpt_q <= rpt_q + W'(rpt_q != CNT_MAX);
          end
        end
        ST_DEB_RELEASE: begin
          if (s_q) state_q <= ST_PUSHED;
          else if (deb_q == DEB_MAX) begin
            state_q <= ST_NOT_PUSHED;
            dout_q  <= !PRESS_PULSE;
            held_q  <= 1'b0;
          end else deb_q <= deb_q + W'(deb_q != CNT_MAX);
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end
endmodule

// File: rtl/button_pulser_array.sv
// button_pulser_array: NUM_BTN independent debounced button pulsers.
module button_pulser_array
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_MODE       = EDGE_RELEASE,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] din,
  output logic [NUM_BTN-1:0] dout,
  output logic [NUM_BTN-1:0] held
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .din (din[i]),
      .dout(dout[i]),
      .held(held[i])
    );
  end
endmodule

// File: tb/tb_button_pulser_array.sv
// tb_button_pulser_array: press, release and auto-repeat variants against a run-length reference model.
module tb_button_pulser_array;
  localparam int D = 4, RD = 8, RR = 4;
  logic clk = 1'b0, rst = 1'b1, chk_en = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] dout_w [3];
  logic [3:0] held_w [3];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  button_pulser_array #(.NUM_BTN(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_press (.clk(clk), .rst(rst), .din(din), .dout(dout_w[0]), .held(held_w[0]));
  button_pulser_array #(.NUM_BTN(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_rel (.clk(clk), .rst(rst), .din(din), .dout(dout_w[1]), .held(held_w[1]));
  button_pulser_array #(.NUM_BTN(4), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_rep (.clk(clk), .rst(rst), .din(din), .dout(dout_w[2]), .held(held_w[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Model: a channel accepts a new level after D+1 consecutive opposite samples of the 2-cycle-delayed input
  bit armed [3][4];
  bit level [3][4];
  int run [3][4];
  int t [3][4];
  logic [3:0] exp_dout [3];
  logic [3:0] exp_held [3];
  logic [3:0] sh1 = '0, sh2 = '0;
  int vc = 0;
  bit ms, mp;
  always @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < 3; m++) begin
        exp_dout[m] = '0;
        exp_held[m] = '0;
        for (int i = 0; i < 4; i++) begin
          armed[m][i] = 0; level[m][i] = 0; run[m][i] = 0; t[m][i] = 0;
        end
      end
      sh1 = '0; sh2 = '0; vc = 0;
    end else begin
      for (int m = 0; m < 3; m++)
        for (int i = 0; i < 4; i++) begin
          ms = sh2[i];
          mp = 0;
          if (!armed[m][i]) armed[m][i] = (vc >= 2) && !ms;
          else begin
            if (m == 2 && level[m][i] && run[m][i] == 0) begin
              t[m][i]++;
              mp = (t[m][i] == RD) || (t[m][i] > RD && (t[m][i] - RD) % RR == 0);
            end
            if (ms != level[m][i]) begin
              if (run[m][i] == D) begin
                level[m][i] = !level[m][i];
                run[m][i] = 0;
                t[m][i] = 0;
                mp = mp | (level[m][i] ? (m != 1) : (m == 1));
              end else run[m][i]++;
            end else run[m][i] = 0;
          end
          exp_dout[m][i] = mp;
          exp_held[m][i] = armed[m][i] && level[m][i];
        end
      sh2 = sh1;
      sh1 = din;
      if (vc < 2) vc++;
    end
  end
  int pc [3][4];
  initial for (int m = 0; m < 3; m++) for (int i = 0; i < 4; i++) pc[m][i] = 0;
  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 4; i++) pc[m][i] += int'(dout_w[m][i] === 1'b1);
      if (chk_en) begin
        check($sformatf("dout_m%0d", m), 32'(dout_w[m]), 32'(exp_dout[m]));
        check($sformatf("held_m%0d", m), 32'(held_w[m]), 32'(exp_held[m]));
      end
    end
  end
  int base [3][4];
  task automatic snap();
    for (int m = 0; m < 3; m++) for (int i = 0; i < 4; i++) base[m][i] = pc[m][i];
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    // clean press on ch0: pulse exactly D+2 edges after the first sampled high
    snap();
    din[0] = 1'b1;
    cyc(6);
    check("lat_early", 32'(dout_w[0][0]), 32'd0);
    cyc(1);
    check("lat_hit", 32'(dout_w[0][0]), 32'd1);
    check("lat_held", 32'(held_w[0][0]), 32'd1);
    cyc(1);
    check("lat_after", 32'(dout_w[0][0]), 32'd0);
    cyc(32);
    din[0] = 1'b0;
    cyc(15);
    check("ch0_press_cnt", 32'(pc[0][0] - base[0][0]), 32'd1);
    check("ch0_rel_cnt", 32'(pc[1][0] - base[1][0]), 32'd1);
    // bouncing input every 2 cycles never qualifies
    snap();
    for (int k = 0; k < 10; k++) begin
      din[1] = ~din[1];
      cyc(2);
    end
    din[1] = 1'b0;
    cyc(15);
    for (int m = 0; m < 3; m++) check($sformatf("bounce_m%0d", m), 32'(pc[m][1] - base[m][1]), 32'd0);
    // held ch2: press pulse plus repeats at +8,+12,...,+28
    snap();
    din[2] = 1'b1;
    cyc(35);
    din[2] = 1'b0;
    cyc(40);
    check("rep_cnt", 32'(pc[2][2] - base[2][2]), 32'd7);
    check("rep_press_cnt", 32'(pc[0][2] - base[0][2]), 32'd1);
    check("rep_rel_cnt", 32'(pc[1][2] - base[1][2]), 32'd1);
    // ch3 held through reset: silent until a fresh press
    din[3] = 1'b1;
    cyc(12);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    snap();
    cyc(10);
    din[3] = 1'b0;
    cyc(15);
    for (int m = 0; m < 3; m++) check($sformatf("rst_hold_m%0d", m), 32'(pc[m][3] - base[m][3]), 32'd0);
    snap();
    din[3] = 1'b1;
    cyc(10);
    din[3] = 1'b0;
    cyc(15);
    check("repress_press", 32'(pc[0][3] - base[0][3]), 32'd1);
    check("repress_rel", 32'(pc[1][3] - base[1][3]), 32'd1);
    // all channels together
    din = 4'hF;
    cyc(7);
    check("all_same_cycle", 32'(dout_w[0]), 32'hF);
    cyc(3);
    din = 4'h0;
    cyc(15);
    // random presses, bounces and occasional resets
    for (int k = 0; k < 900; k++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 9) == 0) din[i] = ~din[i];
      rst = ($urandom_range(0, 249) == 0);
      cyc(1);
    end
    rst = 1'b0;
    din = '0;
    cyc(20);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_pulser_array.md
BUTTON_PULSER_ARRAY -- requirements
Module: button_pulser_array

Interface
REQ-001 Parameter NUM_BTN, default 4: number of independent button channels, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples needed to accept a level change, >=1.
REQ-003 Parameter EDGE_MODE, default 0: 0 = pulse on release, 1 = pulse on press.
REQ-004 Parameter REPEAT_EN, default 0: 1 = auto-repeat while held; legal only with EDGE_MODE=1, otherwise ignored.
REQ-005 Parameter REPEAT_DELAY, default 64: cycles from PUSHED entry to the first repeat pulse, >=1.
REQ-006 Parameter REPEAT_RATE, default 16: cycles between subsequent repeat pulses, >=1.
REQ-007 clk  input  1  sole clock; all state updates on posedge clk.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 din  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
REQ-010 dout  output  NUM_BTN  per-channel single-cycle pulse, registered.
REQ-011 held  output  NUM_BTN  per-channel debounced level, registered; 1 while the channel is in PUSHED or DEB_RELEASE.

Function
REQ-012 Each din bit SHALL pass through a 2-flop synchronizer; s[i] denotes the second flop output.
REQ-013 Each channel SHALL run its own FSM: RESET, NOT_PUSHED, DEB_PRESS, PUSHED, DEB_RELEASE.
REQ-014 RESET -> NOT_PUSHED only when s=0; while s=1 the FSM SHALL stay in RESET, which suppresses pulses from buttons held through reset.
REQ-015 NOT_PUSHED -> DEB_PRESS when s=1, loading the debounce counter with 1.
REQ-016 In DEB_PRESS: s=0 returns the FSM to NOT_PUSHED; s=1 increments the counter; s=1 with count = DEBOUNCE_CYCLES moves the FSM to PUSHED.
REQ-017 PUSHED -> DEB_RELEASE when s=0, loading the counter with 1.
REQ-018 In DEB_RELEASE: s=1 returns the FSM to PUSHED; s=0 increments the counter; s=0 with count = DEBOUNCE_CYCLES moves the FSM to NOT_PUSHED.
REQ-019 EDGE_MODE=1: dout[i] SHALL be high for exactly one cycle, in the cycle after the DEB_PRESS->PUSHED transition.
REQ-020 EDGE_MODE=0: dout[i] SHALL be high for exactly one cycle, in the cycle after the DEB_RELEASE->NOT_PUSHED transition.
REQ-021 Latency: din held high from edge k with clean input, DEBOUNCE_CYCLES=D, EDGE_MODE=1 -> dout high only in the cycle following edge k+D+2.
REQ-022 Repeat (REPEAT_EN=1, EDGE_MODE=1): the repeat counter runs in PUSHED, pauses in DEB_RELEASE, and clears in every other state.
REQ-023 Repeat timing: first extra pulse REPEAT_DELAY cycles after the press pulse, then one pulse every REPEAT_RATE cycles while in PUSHED.
REQ-024 A bounce back from DEB_RELEASE to PUSHED SHALL NOT generate a press pulse; repeat timing resumes from the paused count.
REQ-025 Counters SHALL saturate and never wrap; counter width = $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)+1).
REQ-026 Channels SHALL be fully independent; any number of dout bits may assert in the same cycle.

Reset
REQ-027 rst SHALL clear the synchronizer flops, all counters, dout and held to 0, and force every FSM to RESET, including mid-debounce and mid-repeat.
REQ-028 No dout pulse SHALL be produced during reset or in the cycle rst deasserts.

Structure
REQ-029 The channel state enum (btn_state_t) SHALL live in the shared package btn_pkg, together with the EDGE_PRESS and EDGE_RELEASE constants.
REQ-030 The per-channel synchronizer, FSM and counters SHALL be one sub-module, button_channel, instantiated NUM_BTN times in a generate loop; the top level holds no other logic.

Verification
REQ-031 D=4, EDGE_MODE=1, din[0] clean high at edge 10 -> dout[0] high only in the cycle after edge 16; held[0] high from that cycle.
REQ-032 D=4, din[1] toggling every 2 cycles for 20 cycles then low -> dout[1] never asserts.
REQ-033 D=4, EDGE_MODE=0, press of 10 cycles then release -> exactly one dout pulse, 6 cycles after release; no pulse at press.
REQ-034 REPEAT_EN=1, DELAY=8, RATE=4, button held for 30 cycles after the press pulse -> pulses at +0, +8, +12, +16, +20, +24, +28, then none after release.
REQ-035 Button held across a rst pulse, released, then pressed -> no pulse at reset exit or at the release; exactly one pulse on the new press.
REQ-036 NUM_BTN=4, all four din rise on the same edge -> all four dout bits pulse in the same cycle.
